// File: rtl/button_conditioner.sv
// Front-panel button conditioner: per-channel 2-flop sync, debounce, and press pulse.
// Define BUTTON_AUTOREPEAT_EN to build hold-to-repeat (DELAY/REPEAT); otherwise IDLE/HELD only.
module button_conditioner #(
  parameter int NBTN            = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int CNT_WIDTH       = 22,
  parameter int DEBOUNCE_CYCLES = 25000,
  parameter int REPEAT_DELAY    = 1250000,
  parameter int REPEAT_PERIOD   = 250000
) (
  input  logic            clk_2M5,
  input  logic            reset,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_pulse,
  output logic [NBTN-1:0] btn_level
);

  // state   | meaning
  // IDLE    | debounced level released, waiting for an accepted press
  // HELD    | pressed, single pulse already issued (no auto-repeat build)
  // DELAY   | pressed, counting towards the first repeat pulse
  // REPEAT  | pressed, issuing a pulse every REPEAT_PERIOD cycles
  localparam logic [1:0] ST_IDLE = 2'd0;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;
  localparam logic [CNT_WIDTH-1:0] RD_LAST = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] RP_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);
`else
  localparam logic [1:0] ST_HELD = 2'd1;
`endif
  localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_WIDTH) ||
      REPEAT_DELAY < 1 || longint'(REPEAT_DELAY) > (longint'(1) << CNT_WIDTH) ||
      REPEAT_PERIOD < 1 || longint'(REPEAT_PERIOD) > (longint'(1) << CNT_WIDTH)) begin : g_param_check
    $error("button_conditioner: counter parameters out of range for CNT_WIDTH");
  end

  logic [NBTN-1:0] pressed_raw;
  logic [NBTN-1:0] sync_meta;
  logic [NBTN-1:0] sync;

  assign pressed_raw = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  always_ff @(posedge clk_2M5 or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= pressed_raw;
      sync      <= sync_meta;
    end
  end

  for (genvar i = 0; i < NBTN; i++) begin : g_ch
    logic [CNT_WIDTH-1:0] dcnt;
    logic                 level_q;
    logic                 accept;
    logic                 press;
    logic                 rel;
    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic                 pulse_q;
    logic                 pulse_nxt;
`ifdef BUTTON_AUTOREPEAT_EN
    logic [CNT_WIDTH-1:0] rcnt;
    logic [CNT_WIDTH-1:0] rcnt_nxt;
`endif

    // Any cycle where sync agrees with the accepted level restarts the count.
    assign accept = (sync[i] != level_q) && (dcnt == DB_LAST);
    assign press  = accept & sync[i];
    assign rel    = accept & ~sync[i];

    always_ff @(posedge clk_2M5 or posedge reset) begin
      if (reset) begin
        dcnt    <= '0;
        level_q <= 1'b0;
      end else if (sync[i] == level_q) begin
        dcnt <= '0;
      end else if (dcnt == DB_LAST) begin
        level_q <= sync[i];
        dcnt    <= '0;
      end else begin
        dcnt <= dcnt + CNT_WIDTH'(1);
      end
    end

    always_ff @(posedge clk_2M5 or posedge reset) begin
      if (reset) begin
        state   <= ST_IDLE;
        pulse_q <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
        rcnt    <= '0;
`endif
      end else begin
        state   <= state_nxt;
        pulse_q <= pulse_nxt;
`ifdef BUTTON_AUTOREPEAT_EN
        rcnt    <= rcnt_nxt;
`endif
      end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    always_comb begin
      state_nxt = state;
      rcnt_nxt  = rcnt;
      case (state)
        ST_IDLE: begin
          if (press) begin
            state_nxt = ST_DELAY;
            rcnt_nxt  = '0;
          end
        end
        ST_DELAY: begin
          if (rel) begin
            state_nxt = ST_IDLE;
            rcnt_nxt  = '0;
          end else if (rcnt == RD_LAST) begin
            state_nxt = ST_REPEAT;
            rcnt_nxt  = '0;
          end else if (rcnt < RD_LAST) begin
            rcnt_nxt = rcnt + CNT_WIDTH'(1);
          end
        end
        ST_REPEAT: begin
          if (rel) begin
            state_nxt = ST_IDLE;
            rcnt_nxt  = '0;
          end else if (rcnt == RP_LAST) begin
            rcnt_nxt = '0;
          end else if (rcnt < RP_LAST) begin
            rcnt_nxt = rcnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          rcnt_nxt  = '0;
        end
      endcase
    end

    // Release wins over a repeat pulse landing on the same cycle.
    always_comb begin
      pulse_nxt = 1'b0;
      case (state)
        ST_IDLE:   pulse_nxt = press;
        ST_DELAY:  pulse_nxt = !rel && (rcnt == RD_LAST);
        ST_REPEAT: pulse_nxt = !rel && (rcnt == RP_LAST);
        default:   pulse_nxt = 1'b0;
      endcase
    end
`else
    always_comb begin
      state_nxt = state;
      case (state)
        ST_IDLE: if (press) state_nxt = ST_HELD;
        ST_HELD: if (rel) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end

    always_comb begin
      pulse_nxt = 1'b0;
      case (state)
        ST_IDLE: pulse_nxt = press;
        default: pulse_nxt = 1'b0;
      endcase
    end
`endif

    assign btn_level[i] = level_q;
    assign btn_pulse[i] = pulse_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed segment table, multi-cycle corner sequences,
// and randomized button activity compared every cycle against a timing-rule model.
module tb_button_conditioner;

  localparam int NBTN = 4;
  localparam int DB   = 4;
  localparam int RD   = 20;
  localparam int RP   = 5;

  logic            clk_2M5 = 1'b0;
  logic            reset   = 1'b1;
  logic [NBTN-1:0] btn_raw = 4'hF;
  logic [NBTN-1:0] btn_pulse;
  logic [NBTN-1:0] btn_level;

  always #5 clk_2M5 = ~clk_2M5;

  button_conditioner #(
    .NBTN(NBTN), .ACTIVE_LOW(1), .CNT_WIDTH(22),
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk_2M5  (clk_2M5),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .btn_pulse(btn_pulse),
    .btn_level(btn_level)
  );

  int errors = 0;
  int checks = 0;

  // Model: p1/p2 are the pressed values seen one and two edges ago; run counts
  // consecutive disagreeing samples; t counts edges since the press was accepted.
  typedef struct packed {
    logic [3:0]       p1;
    logic [3:0]       p2;
    logic [3:0]       level;
    logic [3:0]       pulse;
    logic [3:0][7:0]  run;
    logic [3:0][23:0] t;
  } model_t;

  model_t m;

  function automatic model_t model_step(model_t cur, logic [3:0] pressed);
    model_t     n;
    logic [3:0] s;
    logic       acc;
    n       = cur;
    n.pulse = '0;
    s       = cur.p2;
    n.p2    = cur.p1;
    n.p1    = pressed;
    for (int c = 0; c < NBTN; c++) begin
      acc = 1'b0;
      if (s[c] != cur.level[c]) begin
        n.run[c] = cur.run[c] + 8'd1;
        if (int'(n.run[c]) == DB) begin
          n.level[c] = s[c];
          n.run[c]   = '0;
          acc        = 1'b1;
          if (s[c]) begin
            n.pulse[c] = 1'b1;
            n.t[c]     = '0;
          end
        end
      end else begin
        n.run[c] = '0;
      end
      if (!acc && cur.level[c]) begin
        if (cur.t[c] != '1) n.t[c] = cur.t[c] + 24'd1;
`ifdef BUTTON_AUTOREPEAT_EN
        if (int'(n.t[c]) == RD || (int'(n.t[c]) > RD && (int'(n.t[c]) - RD) % RP == 0))
          n.pulse[c] = 1'b1;
`endif
      end
    end
    return n;
  endfunction

  always @(posedge clk_2M5 or posedge reset) begin
    if (reset) m <= '0;
    else       m <= model_step(m, ~btn_raw);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_2M5);
    @(negedge clk_2M5);
    chk("model_level", 32'(btn_level), 32'(m.level));
    chk("model_pulse", 32'(btn_pulse), 32'(m.pulse));
  endtask

  typedef struct packed {
    logic [3:0] raw;
    int         cycles;
    int         exp_pulses;
    logic [3:0] exp_first;
    int         exp_first_edge;
    logic [3:0] exp_level;
  } seg_t;

  seg_t       segs[8];
  int         npulse;
  int         first_edge;
  logic [3:0] first_vec;
  int         got[$];
  int         exp_q[$];
  int         hold[4];
  logic [3:0] pr;

  initial begin
    segs[0] = '{raw: 4'b1110, cycles: 10, exp_pulses: 1, exp_first: 4'b0001, exp_first_edge: 6,  exp_level: 4'b0001};
    segs[1] = '{raw: 4'b1111, cycles: 8,  exp_pulses: 0, exp_first: 4'b0000, exp_first_edge: -1, exp_level: 4'b0000};
    segs[2] = '{raw: 4'b1110, cycles: 3,  exp_pulses: 0, exp_first: 4'b0000, exp_first_edge: -1, exp_level: 4'b0000};
    segs[3] = '{raw: 4'b1111, cycles: 8,  exp_pulses: 0, exp_first: 4'b0000, exp_first_edge: -1, exp_level: 4'b0000};
    segs[4] = '{raw: 4'b0110, cycles: 10, exp_pulses: 2, exp_first: 4'b1001, exp_first_edge: 6,  exp_level: 4'b1001};
    segs[5] = '{raw: 4'b1111, cycles: 8,  exp_pulses: 0, exp_first: 4'b0000, exp_first_edge: -1, exp_level: 4'b0000};
    segs[6] = '{raw: 4'b1101, cycles: 10, exp_pulses: 1, exp_first: 4'b0010, exp_first_edge: 6,  exp_level: 4'b0010};
    segs[7] = '{raw: 4'b1111, cycles: 8,  exp_pulses: 0, exp_first: 4'b0000, exp_first_edge: -1, exp_level: 4'b0000};

    reset   = 1'b1;
    btn_raw = 4'hF;
    repeat (2) tick();
    chk("reset_level", 32'(btn_level), 32'd0);
    chk("reset_pulse", 32'(btn_pulse), 32'd0);
    reset = 1'b0;
    repeat (3) tick();

    // Directed segments: clean press/release, short glitch, simultaneous channels.
    for (int r = 0; r < 8; r++) begin
      npulse     = 0;
      first_edge = -1;
      first_vec  = '0;
      btn_raw    = segs[r].raw;
      for (int k = 1; k <= segs[r].cycles; k++) begin
        tick();
        if (btn_pulse != '0) begin
          npulse += $countones(btn_pulse);
          if (first_edge < 0) begin
            first_edge = k;
            first_vec  = btn_pulse;
          end
        end
      end
      chk($sformatf("seg%0d_pulses", r), 32'(npulse), 32'(segs[r].exp_pulses));
      chk($sformatf("seg%0d_first_edge", r), 32'(first_edge), 32'(segs[r].exp_first_edge));
      chk($sformatf("seg%0d_first_vec", r), 32'(first_vec), 32'(segs[r].exp_first));
      chk($sformatf("seg%0d_level", r), 32'(btn_level), 32'(segs[r].exp_level));
    end

    // Bounce on channel 1: 2-cycle toggles never reach the debounce count.
    npulse = 0;
    for (int i = 0; i < 30; i++) begin
      btn_raw = (((i / 2) % 2) == 0) ? 4'b1111 : 4'b1101;
      tick();
      npulse += int'(btn_pulse[1]);
    end
    chk("bounce_no_pulse", 32'(npulse), 32'd0);
    chk("bounce_level", 32'(btn_level), 32'd0);
    btn_raw    = 4'b1101;
    npulse     = 0;
    first_edge = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (btn_pulse[1]) begin
        npulse++;
        if (first_edge < 0) first_edge = k;
      end
    end
    chk("bounce_pulse_edge", 32'(first_edge), 32'd6);
    chk("bounce_pulse_count", 32'(npulse), 32'd1);
    btn_raw = 4'hF;
    repeat (10) tick();

    // Hold channel 2; release lands so the would-be edge-61 repeat meets the release.
    got.delete();
    exp_q.delete();
    exp_q.push_back(6);
`ifdef BUTTON_AUTOREPEAT_EN
    exp_q.push_back(26); exp_q.push_back(31); exp_q.push_back(36); exp_q.push_back(41);
    exp_q.push_back(46); exp_q.push_back(51); exp_q.push_back(56);
`endif
    btn_raw = 4'b1011;
    for (int k = 1; k <= 70; k++) begin
      if (k == 56) btn_raw = 4'hF;
      tick();
      if (btn_pulse[2]) got.push_back(k);
      if (k == 60) chk("hold_level_before_release", 32'(btn_level[2]), 32'd1);
      if (k == 61) chk("hold_level_after_release", 32'(btn_level[2]), 32'd0);
    end
    chk("hold_pulse_count", 32'(got.size()), 32'(exp_q.size()));
    for (int j = 0; j < got.size() && j < exp_q.size(); j++)
      chk($sformatf("hold_pulse_edge%0d", j), 32'(got[j]), 32'(exp_q[j]));
    repeat (5) tick();

    // Reset mid-hold on channel 2, asserted between edges 15 and 16.
    btn_raw = 4'b1011;
    for (int k = 1; k <= 15; k++) tick();
    chk("prereset_level", 32'(btn_level), 32'b0100);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_level", 32'(btn_level), 32'd0);
    chk("rst_async_pulse", 32'(btn_pulse), 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    got.delete();
    exp_q.delete();
    exp_q.push_back(6);
`ifdef BUTTON_AUTOREPEAT_EN
    exp_q.push_back(26);
`endif
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (btn_pulse[2]) got.push_back(k);
    end
    chk("rst_pulse_count", 32'(got.size()), 32'(exp_q.size()));
    for (int j = 0; j < got.size() && j < exp_q.size(); j++)
      chk($sformatf("rst_pulse_edge%0d", j), 32'(got[j]), 32'(exp_q[j]));
    btn_raw = 4'hF;
    repeat (10) tick();

    // Random activity: mostly short (bouncy) holds, some long enough to repeat.
    pr = '0;
    for (int c = 0; c < NBTN; c++) hold[c] = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int c = 0; c < NBTN; c++) begin
        if (hold[c] == 0) begin
          pr[c]   = 1'($urandom_range(0, 1));
          hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45))
                                                : int'($urandom_range(1, 8));
        end
        hold[c]--;
      end
      btn_raw = ~pr;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
